bcd_scan_display: RTL and testbench
===================================

Name: bcd_scan_display

Overview:
- Downstream consumer of the joystick count stage; takes the latched 7-bit count (0..99) and shows it on a two-digit multiplexed 7-segment display.
- Converts binary to BCD sequentially with a shift-and-add-3 FSM, one bit per clock.
- Scans the two digits at a rate set by a refresh divider.
- Runs on the 10 kHz counter clock; a new value is loaded whenever the upstream register updates.

Parameters:
- WIDTH, 7, width of the binary input value.
- REFRESH_DIV, 50, clock cycles each digit stays enabled before the scan switches (legal range ≥ 2).
- BLANK_LEADING, 1, when 1 the tens digit is blanked if it is 0.

Ports:
- clk  input  1  system clock (same 10 kHz clock as the counter stage)
- reset  input  1  asynchronous, active-low reset
- value  input  WIDTH  binary count from the upstream register
- load  input  1  single-cycle request to convert and display value
- busy  output  1  high while a conversion is in progress
- bcd_tens  output  4  displayed tens digit (registered)
- bcd_ones  output  4  displayed ones digit (registered)
- seg  output  7  segments {g,f,e,d,c,b,a}, active-high
- dig  output  2  one-hot digit enable, active-high: 2'b01 = ones, 2'b10 = tens

Behaviour:
- Reset (reset=0, asynchronous): state IDLE, busy=0, bcd_tens=0, bcd_ones=0, shift registers cleared, refresh counter=0, dig=2'b01. After release, seg=7'h3F (ones digit showing "0").
- FSM states: IDLE, SHIFT, COMMIT.
- IDLE + load=1 at edge n:
  - Capture v = (value > 99) ? 99 : value (clamp, no wrap).
  - Clear the 8-bit BCD scratch register; set bit counter = WIDTH; go to SHIFT.
  - busy=1 from edge n onward.
- IDLE + load=0: stay in IDLE.
- SHIFT, once per cycle:
  - Add 3 to each scratch nibble that is ≥ 5.
  - Shift {scratch, v} left by 1; decrement the bit counter.
  - After WIDTH shifts, go to COMMIT.
- COMMIT:
  - Copy the scratch nibbles to bcd_tens and bcd_ones; busy=0; go to IDLE.
  - Total latency: bcd outputs update at edge n+WIDTH+1 (n+8 at default). busy is high for WIDTH+1 cycles.
- load while busy=1 (SHIFT or COMMIT) is ignored; no queueing. A load in the same cycle COMMIT returns to IDLE is also ignored, because it is sampled in COMMIT.
- The displayed digits never show intermediate conversion values; they change only in COMMIT.
- Scan:
  - The refresh counter runs freely 0..REFRESH_DIV-1, independent of the FSM.
  - On wrap to 0, dig toggles between 2'b01 and 2'b10.
  - Each digit therefore stays enabled for exactly REFRESH_DIV cycles.
- seg is combinational from dig and the registered bcd outputs:
  - When dig=01, seg shows ones; when dig=10, seg shows tens.
  - Digit codes 0..9: 3F, 06, 5B, 4F, 66, 6D, 7D, 07, 7F, 6F.
  - Any nibble >9 gives seg=00 (this state is unreachable after the clamp).
- Blanking: if BLANK_LEADING=1 and bcd_tens=0 while dig=10, seg=00. The ones digit is never blanked, so 0 displays as "0".
- Reset asserted mid-conversion: abort immediately to the reset values. The previous display value is lost.
- dig is never 00 or 11, so exactly one digit is always enabled (glitch-free one-hot).

Test Plan:
- Reset, release, no load -> bcd=0/0, busy=0. For 50 cycles: dig=01, seg=3F. Then for 50 cycles: dig=10, seg=00 (blanked).
- load=1 for one cycle with value=7'd57 -> busy high for 8 cycles. At edge n+8: bcd_tens=5, bcd_ones=7. Scan shows seg=6D on tens and 07 on ones.
- Back-to-back: load value=42, then load value=13 at n+3 -> second load ignored. Result 4/2 at n+8. A new load of 13 after busy falls -> 1/3.
- value=7'd120 loaded -> clamped to 9/9; seg=6F on both digits.
- value=99 loaded, then value=5 -> tens blanked (seg=00 while dig=10), ones seg=6D. Repeat with BLANK_LEADING=0 -> tens seg=3F.
- Assert reset at n+4 during a conversion of 88 -> outputs return to reset values asynchronously. After release: busy=0, bcd=0/0, dig=01.

Source files
------------

// File: rtl/bcd_scan_display.sv
// Two-digit multiplexed 7-segment display for a 0..99 count. Binary input is
// converted to BCD by a sequential shift-and-add-3 engine, one bit per clock.
module bcd_scan_display #(
    parameter int WIDTH         = 7,
    parameter int REFRESH_DIV   = 50,
    parameter int BLANK_LEADING = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] value,
    input  logic             load,
    output logic             busy,
    output logic [3:0]       bcd_tens,
    output logic [3:0]       bcd_ones,
    output logic [6:0]       seg,
    output logic [1:0]       dig
);

    localparam int CNT_W = $clog2(WIDTH + 1);
    localparam int REF_W = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [WIDTH-1:0] MAX_VAL   = WIDTH'(99);
    localparam logic [REF_W-1:0] REF_LAST  = REF_W'(REFRESH_DIV - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        COMMIT = 2'd2
    } state_t;

    state_t             state_r, state_s;
    logic [WIDTH-1:0]   bin_r, bin_s;
    logic [7:0]         scratch_r, scratch_s;
    logic [7:0]         adj_s;
    logic [CNT_W-1:0]   bitcnt_r, bitcnt_s;
    logic               busy_r, busy_s;
    logic [3:0]         tens_r, tens_s;
    logic [3:0]         ones_r, ones_s;
    logic [REF_W-1:0]   refresh_r;
    logic [1:0]         dig_r;

    // Double-dabble correction: a nibble of 5 or more would overflow past 9 once doubled.
    function automatic logic [7:0] add3(input logic [7:0] bcd);
        logic [7:0] res;
        res[3:0] = (bcd[3:0] >= 4'd5) ? (bcd[3:0] + 4'd3) : bcd[3:0];
        res[7:4] = (bcd[7:4] >= 4'd5) ? (bcd[7:4] + 4'd3) : bcd[7:4];
        return res;
    endfunction

    function automatic logic [6:0] seg_decode(input logic [3:0] d);
        logic [6:0] code;
        case (d)
            4'd0:    code = 7'h3F;
            4'd1:    code = 7'h06;
            4'd2:    code = 7'h5B;
            4'd3:    code = 7'h4F;
            4'd4:    code = 7'h66;
            4'd5:    code = 7'h6D;
            4'd6:    code = 7'h7D;
            4'd7:    code = 7'h07;
            4'd8:    code = 7'h7F;
            4'd9:    code = 7'h6F;
            default: code = 7'h00;
        endcase
        return code;
    endfunction

    // Conversion FSM next-state and datapath.
    always_comb begin
        state_s   = state_r;
        bin_s     = bin_r;
        scratch_s = scratch_r;
        bitcnt_s  = bitcnt_r;
        busy_s    = busy_r;
        tens_s    = tens_r;
        ones_s    = ones_r;
        adj_s     = scratch_r;
        case (state_r)
            IDLE: begin
                if (load) begin
                    bin_s     = (value > MAX_VAL) ? MAX_VAL : value;
                    scratch_s = 8'h00;
                    bitcnt_s  = CNT_W'(WIDTH);
                    busy_s    = 1'b1;
                    state_s   = SHIFT;
                end else begin
                    state_s   = IDLE;
                end
            end
            SHIFT: begin
                adj_s              = add3(scratch_r);
                {scratch_s, bin_s} = {adj_s, bin_r} << 1;
                bitcnt_s           = bitcnt_r - CNT_W'(1);
                if (bitcnt_r == CNT_W'(1)) begin
                    state_s = COMMIT;
                end else begin
                    state_s = SHIFT;
                end
            end
            COMMIT: begin
                tens_s  = scratch_r[7:4];
                ones_s  = scratch_r[3:0];
                busy_s  = 1'b0;
                state_s = IDLE;
            end
            default: begin
                busy_s  = 1'b0;
                state_s = IDLE;
            end
        endcase
    end

    // Conversion state and displayed-digit registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r   <= IDLE;
            bin_r     <= '0;
            scratch_r <= 8'h00;
            bitcnt_r  <= '0;
            busy_r    <= 1'b0;
            tens_r    <= 4'd0;
            ones_r    <= 4'd0;
        end else begin
            state_r   <= state_s;
            bin_r     <= bin_s;
            scratch_r <= scratch_s;
            bitcnt_r  <= bitcnt_s;
            busy_r    <= busy_s;
            tens_r    <= tens_s;
            ones_r    <= ones_s;
        end
    end

    // Free-running scan divider; dig only ever swaps between the two one-hot codes.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            refresh_r <= '0;
            dig_r     <= 2'b01;
        end else if (refresh_r == REF_LAST) begin
            refresh_r <= '0;
            dig_r     <= {dig_r[0], dig_r[1]};
        end else begin
            refresh_r <= refresh_r + REF_W'(1);
            dig_r     <= dig_r;
        end
    end

    // Segment mux with optional leading-zero blanking on the tens digit.
    always_comb begin
        seg = 7'h00;
        if (dig_r == 2'b10) begin
            if ((BLANK_LEADING != 0) && (tens_r == 4'd0)) begin
                seg = 7'h00;
            end else begin
                seg = seg_decode(tens_r);
            end
        end else begin
            seg = seg_decode(ones_r);
        end
    end

    assign busy     = busy_r;
    assign bcd_tens = tens_r;
    assign bcd_ones = ones_r;
    assign dig      = dig_r;

endmodule

// File: tb/tb_bcd_scan_display.sv
// Directed bench for bcd_scan_display: a blanking and a non-blanking instance
// share stimulus; expected digits and segment codes are hand-computed.
module tb_bcd_scan_display;

    logic       clk = 1'b0;
    logic       reset;
    logic [6:0] value;
    logic       load;
    logic       busy, busy_nb;
    logic [3:0] bcd_tens, bcd_ones, tens_nb, ones_nb;
    logic [6:0] seg, seg_nb;
    logic [1:0] dig, dig_nb;

    int passed = 0;
    int total  = 0;

    typedef struct {
        logic [6:0] v;
        logic [3:0] t;
        logic [3:0] o;
    } vec_t;

    logic [6:0] codes [10];

    always #5 clk = ~clk;

    bcd_scan_display u_dut (
        .clk(clk), .reset(reset), .value(value), .load(load), .busy(busy),
        .bcd_tens(bcd_tens), .bcd_ones(bcd_ones), .seg(seg), .dig(dig)
    );

    bcd_scan_display #(.BLANK_LEADING(0)) u_nb (
        .clk(clk), .reset(reset), .value(value), .load(load), .busy(busy_nb),
        .bcd_tens(tens_nb), .bcd_ones(ones_nb), .seg(seg_nb), .dig(dig_nb)
    );

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", name, got, exp);
    endtask

    task automatic wait_dig(input logic [1:0] target);
        for (int i = 0; i < 120 && dig !== target; i++) @(negedge clk);
        chk("dig_reach", {30'd0, dig}, {30'd0, target});
    endtask

    // Checks segment output on both digits for both instances.
    task automatic check_scan(input logic [3:0] t, input logic [3:0] o);
        wait_dig(2'b10);
        chk("seg_tens", {25'd0, seg}, (t == 4'd0) ? 32'h0 : {25'd0, codes[t]});
        chk("seg_tens_nb", {25'd0, seg_nb}, {25'd0, codes[t]});
        wait_dig(2'b01);
        chk("seg_ones", {25'd0, seg}, {25'd0, codes[o]});
        chk("seg_ones_nb", {25'd0, seg_nb}, {25'd0, codes[o]});
    endtask

    // One-cycle load; checks busy window, held display, and committed result.
    task automatic convert(input logic [6:0] v, input logic [3:0] pt, input logic [3:0] po,
                           input logic [3:0] et, input logic [3:0] eo);
        value = v;
        load  = 1'b1;
        @(negedge clk);
        load  = 1'b0;
        chk("busy_start", {31'd0, busy}, 32'd1);
        for (int k = 0; k < 7; k++) begin
            @(negedge clk);
            chk("busy_mid", {31'd0, busy}, 32'd1);
            chk("bcd_hold", {24'd0, bcd_tens, bcd_ones}, {24'd0, pt, po});
        end
        @(negedge clk);
        chk("busy_end", {31'd0, busy}, 32'd0);
        chk("bcd_result", {24'd0, bcd_tens, bcd_ones}, {24'd0, et, eo});
        chk("bcd_result_nb", {24'd0, tens_nb, ones_nb}, {24'd0, et, eo});
    endtask

    initial begin
        vec_t vecs [10];
        logic [3:0] pt, po;

        codes = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};
        vecs = '{
            '{7'd57,  4'd5, 4'd7}, '{7'd120, 4'd9, 4'd9}, '{7'd99, 4'd9, 4'd9},
            '{7'd5,   4'd0, 4'd5}, '{7'd0,   4'd0, 4'd0}, '{7'd10, 4'd1, 4'd0},
            '{7'd127, 4'd9, 4'd9}, '{7'd100, 4'd9, 4'd9}, '{7'd64, 4'd6, 4'd4},
            '{7'd89,  4'd8, 4'd9}
        };

        reset = 1'b0;
        load  = 1'b0;
        value = 7'd0;
        repeat (3) @(negedge clk);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_bcd", {24'd0, bcd_tens, bcd_ones}, 32'd0);
        reset = 1'b1;

        // Idle scan after reset: 50 cycles on ones, 50 on blanked tens.
        for (int i = 0; i < 100; i++) begin
            chk("idle_dig", {30'd0, dig}, (i < 50) ? 32'd1 : 32'd2);
            chk("idle_seg", {25'd0, seg}, (i < 50) ? 32'h3F : 32'h00);
            chk("idle_seg_nb", {25'd0, seg_nb}, 32'h3F);
            @(negedge clk);
        end
        chk("idle_busy", {31'd0, busy}, 32'd0);

        pt = 4'd0;
        po = 4'd0;
        for (int i = 0; i < 10; i++) begin
            convert(vecs[i].v, pt, po, vecs[i].t, vecs[i].o);
            check_scan(vecs[i].t, vecs[i].o);
            pt = vecs[i].t;
            po = vecs[i].o;
        end

        // Back-to-back: load of 13 at n+3 and at the COMMIT cycle are both ignored.
        value = 7'd42;
        load  = 1'b1;
        @(negedge clk);
        load  = 1'b0;
        repeat (2) @(negedge clk);
        value = 7'd13;
        load  = 1'b1;
        @(negedge clk);
        load  = 1'b0;
        repeat (4) @(negedge clk);
        chk("b2b_busy", {31'd0, busy}, 32'd1);
        load  = 1'b1;
        @(negedge clk);
        load  = 1'b0;
        chk("b2b_busy_end", {31'd0, busy}, 32'd0);
        chk("b2b_bcd", {24'd0, bcd_tens, bcd_ones}, 32'h42);
        @(negedge clk);
        chk("commit_load_ignored", {31'd0, busy}, 32'd0);
        convert(7'd13, 4'd4, 4'd2, 4'd1, 4'd3);
        check_scan(4'd1, 4'd3);

        // Reset asserted mid-conversion of 88.
        value = 7'd88;
        load  = 1'b1;
        @(negedge clk);
        load  = 1'b0;
        repeat (3) @(negedge clk);
        @(posedge clk);
        #2 reset = 1'b0;
        #1;
        chk("midrst_busy", {31'd0, busy}, 32'd0);
        chk("midrst_bcd", {24'd0, bcd_tens, bcd_ones}, 32'd0);
        chk("midrst_dig", {30'd0, dig}, 32'd1);
        @(negedge clk);
        reset = 1'b1;
        repeat (3) @(negedge clk);
        chk("post_busy", {31'd0, busy}, 32'd0);
        chk("post_bcd", {24'd0, bcd_tens, bcd_ones}, 32'd0);
        chk("post_dig", {30'd0, dig}, 32'd1);
        chk("post_seg", {25'd0, seg}, 32'h3F);
        repeat (10) @(negedge clk);
        chk("post_still_idle", {31'd0, busy}, 32'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
